// File: rtl/tx_frame_ser_if.sv
// Frame-request and TX FIFO signal bundle for tx_frame_ser.
// The master drives the frame request and FIFO status; the slave is the serializer.
interface tx_frame_ser_if;
   logic [55:0] pdata;
   logic        frame_vld;
   logic        fifo_full;
   logic        ready;
   logic [7:0]  tx_data;
   logic        tx_wr_en;
   logic        done;
   logic        err;

   modport master (
      output pdata, frame_vld, fifo_full,
      input  ready, tx_data, tx_wr_en, done, err
   );

   modport slave (
      input  pdata, frame_vld, fifo_full,
      output ready, tx_data, tx_wr_en, done, err
   );
endinterface

// File: rtl/tx_frame_ser.sv
// Serializes a latched 7-slot response frame into the TX FIFO one byte per cycle.
// Frame length is decoded from the cmd byte at accept time.
module tx_frame_ser (
   input  logic          clk,
   input  logic          rst,
   tx_frame_ser_if.slave bus
);
   typedef enum logic {IDLE, SEND} state_t;

   state_t      state, state_nxt;
   logic [55:0] shadow, shadow_nxt;
   logic [2:0]  idx, idx_nxt;
   logic [2:0]  last, last_nxt;
   logic        err_q, err_nxt;
   logic [7:0]  cur_byte;
   logic        dec_ok;
   logic [2:0]  dec_last;
   logic        wr;

   always_comb begin
      dec_ok   = 1'b1;
      dec_last = 3'd0;
      case (bus.pdata[50:48])
         3'd2:    dec_last = 3'd6;
         3'd3:    dec_last = 3'd2;
         3'd4:    dec_last = 3'd4;
         default: dec_ok   = 1'b0;
      endcase
   end

   // Index 0 is the cmd byte, i.e. the most significant slot.
   always_comb begin
      case (idx)
         3'd0:    cur_byte = shadow[55:48];
         3'd1:    cur_byte = shadow[47:40];
         3'd2:    cur_byte = shadow[39:32];
         3'd3:    cur_byte = shadow[31:24];
         3'd4:    cur_byte = shadow[23:16];
         3'd5:    cur_byte = shadow[15:8];
         3'd6:    cur_byte = shadow[7:0];
         default: cur_byte = '0;
      endcase
   end

   always_comb begin
      state_nxt    = state;
      shadow_nxt   = shadow;
      idx_nxt      = idx;
      last_nxt     = last;
      err_nxt      = 1'b0;
      wr           = 1'b0;
      bus.ready    = 1'b0;
      bus.tx_wr_en = 1'b0;
      bus.tx_data  = '0;
      bus.done     = 1'b0;
      case (state)
         IDLE: begin
            bus.ready = 1'b1;
            if (bus.frame_vld) begin
               if (dec_ok) begin
                  shadow_nxt = bus.pdata;
                  last_nxt   = dec_last;
                  idx_nxt    = '0;
                  state_nxt  = SEND;
               end else begin
                  err_nxt = 1'b1;
               end
            end
         end
         SEND: begin
            err_nxt      = bus.frame_vld;
            wr           = !bus.fifo_full;
            bus.tx_wr_en = wr;
            bus.tx_data  = cur_byte;
            if (wr) begin
               if (idx == last) begin
                  bus.done  = 1'b1;
                  idx_nxt   = '0;
                  state_nxt = IDLE;
               end else begin
                  idx_nxt = idx + 3'd1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         shadow <= '0;
         idx    <= '0;
         last   <= '0;
         err_q  <= 1'b0;
      end else begin
         state  <= state_nxt;
         shadow <= shadow_nxt;
         idx    <= idx_nxt;
         last   <= last_nxt;
         err_q  <= err_nxt;
      end
   end

   assign bus.err = err_q;
endmodule

// File: doc/tx_frame_ser.md
TX_FRAME_SER -- requirements
Module: tx_frame_ser

Interface
REQ-001 Parameters: none; frame format fixed at 7 byte slots of 8 bits.
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 pdata  input  56  response frame; byte0 = pdata[55:48] (cmd byte) ... byte6 = pdata[7:0].
REQ-005 frame_vld  input  1  frame request pulse; sampled every cycle.
REQ-006 fifo_full  input  1  TX FIFO full flag; no byte is written while high.
REQ-007 ready  output  1  high when idle and able to accept a frame.
REQ-008 tx_data  output  8  byte presented to the TX FIFO.
REQ-009 tx_wr_en  output  1  TX FIFO write strobe; one byte is written per cycle it is high.
REQ-010 done  output  1  one-cycle pulse coincident with the last byte write of a frame.
REQ-011 err  output  1  one-cycle pulse on an illegal cmd or on frame_vld while busy.

Function
REQ-012 The block shall use two states, IDLE and SEND; ready shall equal (state == IDLE).
REQ-013 The block shall accept the frame in IDLE when frame_vld = 1: pdata is latched into a 56-bit shadow register, the byte index is cleared, and the block moves to SEND on the next edge.
REQ-014 Frame length shall decode from pdata[50:48] at accept: 3'd2 (WREQ) -> 7 bytes, 3'd3 (RREQ) -> 3 bytes, 3'd4 (RRES) -> 5 bytes.
REQ-015 Any other cmd value shall leave the block in IDLE, shall produce no writes, and shall pulse err for one cycle, in the cycle after frame_vld.
REQ-016 In SEND: tx_wr_en = !fifo_full; tx_data = shadow byte[index], where index 0 selects shadow[55:48].
REQ-017 tx_data shall hold the current byte stable while fifo_full stalls the transfer.
REQ-018 The byte index (3 bits) shall increment only on a cycle with tx_wr_en = 1; fifo_full = 1 shall freeze the index and the state.
REQ-019 When tx_wr_en = 1 and index == length-1, done shall be 1 in that cycle, the index shall clear, and the state shall return to IDLE on the next edge.
REQ-020 Latency: with fifo_full = 0 and frame_vld at cycle N, writes shall occur at cycles N+1..N+L, done at N+L, and ready high at N+L+1.
REQ-021 frame_vld while in SEND, including the cycle of the last write, shall be ignored (shadow and length unchanged) and shall pulse err one cycle later.
REQ-022 tx_wr_en shall be 0 in IDLE.
REQ-023 tx_data shall be 8'h00 in IDLE.
REQ-024 A frame accepted at N+L+1 (back-to-back) shall write its first byte at N+L+2.
REQ-025 Length and shadow shall not change during SEND; a pdata change mid-frame shall not affect the bytes sent.
REQ-026 The block shall never issue more than L writes per accepted frame, and fifo_full asserted at any time shall not drop or repeat a byte.

Reset
REQ-027 With rst low: state = IDLE, index = 0, shadow = 0, ready = 1, tx_wr_en = 0, tx_data = 8'h00, done = 0, err = 0.
REQ-028 Reset asserted mid-frame shall abort the frame immediately (asynchronous); no further byte of that frame shall be written after rst deasserts.

Verification
REQ-029 WREQ frame: pdata = 56'h02_11_22_33_44_55_66, fifo_full = 0 -> 7 writes 02,11,22,33,44,55,66 on consecutive cycles; done with byte 66; ready returns next cycle.
REQ-030 RREQ frame: pdata = 56'h03_A0_B1_xx.., with fifo_full high for 2 cycles after the first byte -> writes 03,A0,B1 only; A0 is held on tx_data during the stall; tx_wr_en is 0 for exactly 2 cycles.
REQ-031 RRES frame: pdata = 56'h04_10_20_30_40_xx_xx -> 5 writes; frame_vld pulsed during byte 3 -> err pulse; the sequence is unaltered.
REQ-032 Illegal cmd: pdata[50:48] = 3'd7 -> err pulse one cycle later; no tx_wr_en; ready stays 1.
REQ-033 Reset mid-frame: rst low after 4 bytes of a WREQ frame -> outputs at reset values at once; no further writes; a new RREQ frame after release sends 3 correct bytes.
REQ-034 Back-to-back: RREQ accepted on the first ready cycle after a WREQ -> 10 writes total; exactly one idle cycle between frames; two done pulses.
